// File: rtl/fixedpoint_pkg.sv
// Shared signed Q4.4 fixed-point definitions for the product/accumulate/result stages.
// No logic, types and constants only.
// No flow control of its own.
package fixedpoint_pkg;

    localparam int FRAC_BITS = 4;
    localparam int Q44_W     = 8;

    localparam logic signed [Q44_W-1:0] Q44_MAX = 8'sh7F;
    localparam logic signed [Q44_W-1:0] Q44_MIN = 8'sh80;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Registered frame result: clamped Q4.4 value plus its saturation flag
    typedef struct packed {
        logic             ovf;
        logic [Q44_W-1:0] dat;
    } q44_res_t;

endpackage

// File: rtl/fixedpoint_sat_s.sv
// Clamps a wide signed Q(W-4).4 value to signed Q4.4 and flags saturation.
// Purely combinational, zero latency.
// No handshake; output follows input.
module fixedpoint_sat_s
    import fixedpoint_pkg::*;
#(
    parameter int W = 12
) (
    input  logic signed [W-1:0]     din,
    output logic        [Q44_W-1:0] dout,
    output logic                    ovf
);

    // Q4.4 limits sign-extended to the input width; fraction alignment is unchanged
    localparam logic signed [W-1:0] HI = {{(W-Q44_W){Q44_MAX[Q44_W-1]}}, Q44_MAX};
    localparam logic signed [W-1:0] LO = {{(W-Q44_W){Q44_MIN[Q44_W-1]}}, Q44_MIN};

    always_comb begin
        dout = din[Q44_W-1:0];
        ovf  = 1'b0;
        if (din > HI) begin
            dout = Q44_MAX;
            ovf  = 1'b1;
        end else if (din < LO) begin
            dout = Q44_MIN;
            ovf  = 1'b1;
        end
    end

endmodule

// File: rtl/fixedpoint_acc_s.sv
// Accumulates LEN signed Q4.4 products per frame and emits one saturated Q4.4 sum.
// Result valid the cycle after the LEN-th accepted product; one input bubble between frames.
// in_ready low while a result is held; result held stable until out_ready.
module fixedpoint_acc_s
    import fixedpoint_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q44_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q44_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(LEN);

    generate
        if (ACC_W < Q44_W + $clog2(LEN)) begin : g_width_chk
            $error("fixedpoint_acc_s: ACC_W too narrow, accumulator could wrap");
        end
    endgenerate

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    q44_res_t                res;
    q44_res_t                sat_res;
    logic                    accept;
    logic                    last;

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CNT_W'(LEN - 1));
    assign sum       = acc + {{(ACC_W-Q44_W){in_data[Q44_W-1]}}, in_data};

    fixedpoint_sat_s #(
        .W (ACC_W)
    ) u_sat (
        .din  (sum),
        .dout (sat_res.dat),
        .ovf  (sat_res.ovf)
    );

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_ACC;
        end else begin
            case (state)
                ST_ACC:  if (accept && last) state_nxt = ST_HOLD;
                ST_HOLD: if (out_ready)      state_nxt = ST_ACC;
                default:                     state_nxt = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACC;
        else        state <= state_nxt;
    end

    // clr only resets the running sum; a held result is dropped via the FSM but its value stays
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            res <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
                res <= sat_res;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out_data = res.dat;
    assign out_ovf  = res.ovf;

endmodule

// File: tb/tb_fixedpoint_acc_s.sv
// Directed bench for fixedpoint_acc_s (LEN=4, ACC_W=12) with hand-computed Q4.4 results.
module tb_fixedpoint_acc_s;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;

    int vectors;
    int miscompares;

    fixedpoint_acc_s #(
        .LEN   (4),
        .ACC_W (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted product; inputs change 1 time unit after the edge
    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = 8'hXX;
    endtask

    task automatic check_result(input string tag, input logic [7:0] dat, input logic ovf);
        check({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
        check({tag, "_data"},  out_data,          dat);
        check({tag, "_ovf"},   {7'd0, out_ovf},   {7'd0, ovf});
        check({tag, "_rdy"},   {7'd0, in_ready},  8'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clr         = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b1;

        // Reset state
        step();
        step();
        check("rst_valid", {7'd0, out_valid}, 8'd0);
        check("rst_data",  out_data,          8'h00);
        check("rst_ovf",   {7'd0, out_ovf},   8'd0);
        rst_n = 1'b1;
        step();
        check("rst_rdy", {7'd0, in_ready}, 8'd1);

        // 1.0 x4 = 4.0, result valid for exactly one cycle with out_ready high
        send(8'h10); send(8'h10); send(8'h10); send(8'h10);
        check_result("t1", 8'h40, 1'b0);
        step();
        check("t1_drop_valid", {7'd0, out_valid}, 8'd0);
        check("t1_back_rdy",   {7'd0, in_ready},  8'd1);
        check("t1_hold_data",  out_data,          8'h40);

        // 1.5 - 1.5 + 0.25 + 0.25 = 0.5
        send(8'h18); send(8'hE8); send(8'h04); send(8'h04);
        check_result("t2", 8'h08, 1'b0);
        step();

        // 28.0 clamps high, -32.0 clamps low
        send(8'h70); send(8'h70); send(8'h70); send(8'h70);
        check_result("t3_pos", 8'h7F, 1'b1);
        step();
        send(8'h80); send(8'h80); send(8'h80); send(8'h80);
        check_result("t3_neg", 8'h80, 1'b1);
        step();

        // Backpressure: result held, in_data ignored while not ready
        out_ready = 1'b0;
        send(8'h10); send(8'h10); send(8'h10); send(8'h10);
        check_result("t4_hold0", 8'h40, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        check_result("t4_hold1", 8'h40, 1'b0);
        step();
        check_result("t4_hold2", 8'h40, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("t4_release_valid", {7'd0, out_valid}, 8'd0);
        check("t4_release_rdy",   {7'd0, in_ready},  8'd1);

        // 2.0 x4 with idle gaps = 8.0, just above the Q4.4 maximum
        send(8'h20); step();
        send(8'h20); step(); step(); step();
        send(8'h20); step();
        send(8'h20);
        check_result("t4_gap", 8'h7F, 1'b1);
        step();

        // Async reset mid-frame discards the partial sum and clears the outputs
        send(8'h30); send(8'h30);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {7'd0, out_valid}, 8'd0);
        check("t5_rst_data",  out_data,          8'h00);
        check("t5_rst_ovf",   {7'd0, out_ovf},   8'd0);
        step();
        rst_n = 1'b1;
        step();
        send(8'h10); send(8'h10); send(8'h10); send(8'h10);
        check_result("t5", 8'h40, 1'b0);
        step();

        // clr with a same-cycle product drops the partial frame and that product
        send(8'h10); send(8'h10); send(8'h10);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h10;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_valid", {7'd0, out_valid}, 8'd0);
        send(8'h08); send(8'h08); send(8'h08); send(8'h08);
        check_result("t6", 8'h20, 1'b0);
        step();

        // clr while holding drops the result but leaves the data register untouched
        out_ready = 1'b0;
        send(8'h10); send(8'h10); send(8'h10); send(8'h10);
        check_result("t7_hold", 8'h40, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t7_clr_valid", {7'd0, out_valid}, 8'd0);
        check("t7_clr_rdy",   {7'd0, in_ready},  8'd1);
        check("t7_clr_data",  out_data,          8'h40);
        out_ready = 1'b1;
        send(8'hF0); send(8'hF0); send(8'h04); send(8'h00);
        check_result("t7_after", 8'hE4, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
